// File: rtl/fu_cluster_pkg.sv
// rtl/fu_cluster_pkg.sv - shared types, widths and ROB age helper for the ALU cluster
package fu_cluster_pkg;

  localparam int ROB_TAG_W = 5;
  localparam int PREG_W    = 6;
  localparam int XLEN      = 32;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT,
    ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef struct packed {
    alu_op_e              op;
    logic [ROB_TAG_W-1:0] tag;
    logic [PREG_W-1:0]    pdst;
    logic [XLEN-1:0]      imm;
    logic                 use_imm;
  } rs_data_t;

  typedef struct packed {
    logic [XLEN-1:0]      result;
    logic [ROB_TAG_W-1:0] tag;
    logic [PREG_W-1:0]    pdst;
  } alu_data_t;

  // Ages are distances from the ROB head, so the comparison survives tag wrap.
  function automatic logic is_younger(input logic [ROB_TAG_W-1:0] tag,
                                      input logic [ROB_TAG_W-1:0] mtag,
                                      input logic [ROB_TAG_W-1:0] head);
    logic [ROB_TAG_W-1:0] age;
    logic [ROB_TAG_W-1:0] mage;
    age  = tag - head;
    mage = mtag - head;
    return age > mage;
  endfunction

endpackage

// File: rtl/fu_cluster_if.sv
// rtl/fu_cluster_if.sv - issue, flush and completion bus between the RS/ROB and the cluster
interface fu_cluster_if #(
  parameter int NUM_LANES = 2,
  parameter int NUM_CDB   = 1
);
  import fu_cluster_pkg::*;

  logic [NUM_LANES-1:0]           issue_valid;
  rs_data_t [NUM_LANES-1:0]       issue_data;
  logic [NUM_LANES-1:0][XLEN-1:0] ps1_data;
  logic [NUM_LANES-1:0][XLEN-1:0] ps2_data;
  logic [NUM_LANES-1:0]           issue_ready;
  logic [ROB_TAG_W-1:0]           rob_head;
  logic                           mispredict;
  logic [ROB_TAG_W-1:0]           mispredict_tag;
  logic [NUM_CDB-1:0]             cdb_valid;
  alu_data_t [NUM_CDB-1:0]        cdb_data;

  modport master (
    output issue_valid, issue_data, ps1_data, ps2_data,
    output rob_head, mispredict, mispredict_tag,
    input  issue_ready, cdb_valid, cdb_data
  );

  modport slave (
    input  issue_valid, issue_data, ps1_data, ps2_data,
    input  rob_head, mispredict, mispredict_tag,
    output issue_ready, cdb_valid, cdb_data
  );

endinterface

// File: rtl/fu_cluster_alu_lane.sv
// rtl/fu_cluster_alu_lane.sv - one single-cycle ALU lane with its result FIFO and flush logic
module alu_lane
  import fu_cluster_pkg::*;
#(
  parameter int BUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  rs_data_t             issue_data,
  input  logic [XLEN-1:0]      ps1_data,
  input  logic [XLEN-1:0]      ps2_data,
  output logic                 issue_ready,
  input  logic [ROB_TAG_W-1:0] rob_head,
  input  logic                 mispredict,
  input  logic [ROB_TAG_W-1:0] mispredict_tag,
  output logic                 head_valid,
  output alu_data_t            head_data,
  input  logic                 grant
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]      op_b;
  logic [XLEN-1:0]      result;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [BUF_DEPTH-1:0] slot_valid;
  alu_data_t            slot_data [BUF_DEPTH];
  logic                 not_empty;
  logic                 push;
  logic                 pop;

  assign op_b = issue_data.use_imm ? issue_data.imm : ps2_data;

  always_comb begin
    result = '0;
    case (issue_data.op)
      ALU_ADD:  result = ps1_data + op_b;
      ALU_SUB:  result = ps1_data - op_b;
      ALU_AND:  result = ps1_data & op_b;
      ALU_OR:   result = ps1_data | op_b;
      ALU_XOR:  result = ps1_data ^ op_b;
      ALU_SLT:  result = {{(XLEN-1){1'b0}}, $signed(ps1_data) < $signed(op_b)};
      ALU_SLTU: result = {{(XLEN-1){1'b0}}, ps1_data < op_b};
      ALU_SLL:  result = ps1_data << op_b[4:0];
      ALU_SRL:  result = ps1_data >> op_b[4:0];
      ALU_SRA:  result = $unsigned($signed(ps1_data) >>> op_b[4:0]);
      ALU_LUI:  result = op_b;
      default:  result = '0;
    endcase
  end

  // Credit comes from the registered count only; a pop this cycle frees space next cycle.
  assign issue_ready = count < CNT_W'(BUF_DEPTH);
  assign not_empty   = count != '0;
  assign push        = issue_valid && issue_ready &&
                       !(mispredict && is_younger(issue_data.tag, mispredict_tag, rob_head));
  assign head_data   = slot_data[rd_ptr];
  assign head_valid  = not_empty && slot_valid[rd_ptr] &&
                       !(mispredict && is_younger(head_data.tag, mispredict_tag, rob_head));
  // Flushed heads retire silently, one per cycle, without using a CDB port.
  assign pop         = (grant && head_valid) || (not_empty && !slot_valid[rd_ptr]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      slot_valid <= '0;
    end else begin
      for (int s = 0; s < BUF_DEPTH; s++) begin
        if (mispredict && is_younger(slot_data[s].tag, mispredict_tag, rob_head))
          slot_valid[s] <= 1'b0;
      end
      if (pop) begin
        slot_valid[rd_ptr] <= 1'b0;
        rd_ptr             <= rd_ptr + PTR_W'(1);
      end
      if (push) begin
        slot_valid[wr_ptr] <= 1'b1;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      slot_data[wr_ptr] <= '{result: result, tag: issue_data.tag, pdst: issue_data.pdst};
  end

endmodule

// File: rtl/fu_cluster.sv
// rtl/fu_cluster.sv - ALU lanes sharing NUM_CDB completion ports through a round-robin arbiter
module fu_cluster
  import fu_cluster_pkg::*;
#(
  parameter int NUM_LANES = 2,
  parameter int NUM_CDB   = 1,
  parameter int BUF_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  fu_cluster_if.slave bus
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

  logic [NUM_LANES-1:0] head_valid;
  logic [NUM_LANES-1:0] grant;
  alu_data_t            head_data [NUM_LANES];
  logic [LANE_W-1:0]    rr_ptr;
  logic [LANE_W-1:0]    rr_next;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    alu_lane #(.BUF_DEPTH(BUF_DEPTH)) u_lane (
      .clk            (clk),
      .reset          (reset),
      .issue_valid    (bus.issue_valid[i]),
      .issue_data     (bus.issue_data[i]),
      .ps1_data       (bus.ps1_data[i]),
      .ps2_data       (bus.ps2_data[i]),
      .issue_ready    (bus.issue_ready[i]),
      .rob_head       (bus.rob_head),
      .mispredict     (bus.mispredict),
      .mispredict_tag (bus.mispredict_tag),
      .head_valid     (head_valid[i]),
      .head_data      (head_data[i]),
      .grant          (grant[i])
    );
  end

  // Walk lanes from rr_ptr, handing out ports from 0 upward until they run out.
  always_comb begin
    int idx;
    int used;
    grant         = '0;
    bus.cdb_valid = '0;
    bus.cdb_data  = '0;
    rr_next       = rr_ptr;
    idx           = 0;
    used          = 0;
    for (int j = 0; j < NUM_LANES; j++) begin
      idx = (int'(rr_ptr) + j) % NUM_LANES;
      if (head_valid[idx] && used < NUM_CDB) begin
        grant[idx]          = 1'b1;
        bus.cdb_valid[used] = 1'b1;
        bus.cdb_data[used]  = head_data[idx];
        used                = used + 1;
        rr_next             = LANE_W'((idx + 1) % NUM_LANES);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rr_ptr <= '0;
    else        rr_ptr <= rr_next;
  end

endmodule

// File: tb/tb_fu_cluster.sv
// tb/tb_fu_cluster.sv - scoreboard bench for fu_cluster: ALU ops, arbitration, credit, flush, reset
module tb_fu_cluster;
  import fu_cluster_pkg::*;

  localparam int NL = 2;
  localparam int NC = 1;
  localparam int BD = 4;

  typedef struct {
    alu_op_e     op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic        use_imm;
    logic [31:0] want;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fu_cluster_if #(.NUM_LANES(NL), .NUM_CDB(NC)) bus ();
  fu_cluster #(.NUM_LANES(NL), .NUM_CDB(NC), .BUF_DEPTH(BD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int        vectors = 0;
  int        errors  = 0;
  alu_data_t exp_q [NL][$];
  int        occ [NL];
  int        grant_log [$];
  bit        log_grants = 1'b0;
  alu_data_t got;
  alu_data_t want;
  int        mon_ln;
  vec_t      tbl [14];

  always @(negedge clk) begin
    for (int k = 0; k < NC; k++) begin
      if (bus.cdb_valid[k] === 1'b1) begin
        got    = bus.cdb_data[k];
        mon_ln = int'(got.pdst[PREG_W-1]);
        vectors++;
        if (exp_q[mon_ln].size() == 0) begin
          errors++;
          $display("FAIL cdb_unexpected port=%0d got tag=%0d pdst=%0d result=%h, required no output",
                   k, got.tag, got.pdst, got.result);
        end else begin
          want = exp_q[mon_ln].pop_front();
          if (got !== want) begin
            errors++;
            $display("FAIL cdb_data lane=%0d got result=%h tag=%0d pdst=%0d, required result=%h tag=%0d pdst=%0d",
                     mon_ln, got.result, got.tag, got.pdst, want.result, want.tag, want.pdst);
          end
        end
        occ[mon_ln]--;
        if (log_grants) grant_log.push_back(mon_ln);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    bus.issue_valid = '0;
    bus.mispredict  = 1'b0;
  endtask

  task automatic set_issue(input int ln, input alu_op_e op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] imm, input logic use_imm,
                           input logic [4:0] tag, input logic [4:0] pd, input logic [31:0] res,
                           input bit expect_push);
    logic [5:0] pdst;
    pdst = {ln[0], pd};
    bus.issue_valid[ln] = 1'b1;
    bus.issue_data[ln]  = '{op: op, tag: tag, pdst: pdst, imm: imm, use_imm: use_imm};
    bus.ps1_data[ln]    = a;
    bus.ps2_data[ln]    = b;
    vectors++;
    if (bus.issue_ready[ln] !== 1'b1) begin
      errors++;
      $display("FAIL issue_dropped lane=%0d issue_ready=%b, required 1", ln, bus.issue_ready[ln]);
    end else if (expect_push) begin
      exp_q[ln].push_back('{result: res, tag: tag, pdst: pdst});
      occ[ln]++;
    end
  endtask

  function automatic int pending();
    int n = 0;
    for (int i = 0; i < NL; i++) n += exp_q[i].size();
    return n;
  endfunction

  task automatic drain(input string what);
    int n = 0;
    while (pending() != 0 && n < 60) begin
      step();
      n++;
    end
    vectors++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL %s_drain_timeout outstanding=%0d, required 0", what, pending());
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    reset               = 1'b0;
    bus.issue_valid     = '0;
    bus.issue_data      = '0;
    bus.ps1_data        = '0;
    bus.ps2_data        = '0;
    bus.rob_head        = '0;
    bus.mispredict      = 1'b0;
    bus.mispredict_tag  = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.cdb_valid !== '0) begin
      errors++;
      $display("FAIL reset_cdb_valid got %b, required 0", bus.cdb_valid);
    end
    vectors++;
    if (bus.issue_ready !== {NL{1'b1}}) begin
      errors++;
      $display("FAIL reset_issue_ready got %b, required %b", bus.issue_ready, {NL{1'b1}});
    end
    reset = 1'b1;
    step();
  endtask

  task automatic test_add();
    step();
    set_issue(0, ALU_ADD, 32'd5, 32'd7, 32'h0, 1'b0, 5'd1, 5'd1, 32'd12, 1'b1);
    #3;
    vectors++;
    if (bus.cdb_valid !== '0) begin
      errors++;
      $display("FAIL add_no_bypass cdb_valid=%b, required 0 in issue cycle", bus.cdb_valid);
    end
    step();
    vectors++;
    if (bus.cdb_valid[0] !== 1'b1 || bus.cdb_data[0].result !== 32'd12) begin
      errors++;
      $display("FAIL add_t1 cdb_valid=%b result=%h, required 1 and 0000000c",
               bus.cdb_valid[0], bus.cdb_data[0].result);
    end
    drain("add");
  endtask

  task automatic test_ops();
    tbl[0]  = '{ALU_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h0000DEAD, 1'b0, 32'h00000000};
    tbl[1]  = '{ALU_SUB,  32'h00000000, 32'h00000001, 32'h0000DEAD, 1'b0, 32'hFFFFFFFF};
    tbl[2]  = '{ALU_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0000DEAD, 1'b0, 32'hF000F000};
    tbl[3]  = '{ALU_OR,   32'hF0F0F0F0, 32'h0F0F0000, 32'h0000DEAD, 1'b0, 32'hFFFFF0F0};
    tbl[4]  = '{ALU_XOR,  32'hAAAA5555, 32'hFFFF0000, 32'h0000DEAD, 1'b0, 32'h55555555};
    tbl[5]  = '{ALU_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h0000DEAD, 1'b0, 32'h00000001};
    tbl[6]  = '{ALU_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h0000DEAD, 1'b0, 32'h00000001};
    tbl[7]  = '{ALU_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h0000DEAD, 1'b0, 32'h00000000};
    tbl[8]  = '{ALU_SLL,  32'h00000001, 32'h00000025, 32'h0000DEAD, 1'b0, 32'h00000020};
    tbl[9]  = '{ALU_SRL,  32'h80000000, 32'h00000000, 32'h00000004, 1'b1, 32'h08000000};
    tbl[10] = '{ALU_SRA,  32'h80000000, 32'h00000000, 32'h00000004, 1'b1, 32'hF8000000};
    tbl[11] = '{ALU_LUI,  32'h00000077, 32'h00000000, 32'h12345000, 1'b1, 32'h12345000};
    tbl[12] = '{ALU_ADD,  32'h0000000A, 32'h000003E7, 32'hFFFFFFFE, 1'b1, 32'h00000008};
    tbl[13] = '{ALU_SLT,  32'h00000005, 32'h00000003, 32'h0000DEAD, 1'b0, 32'h00000000};
    for (int k = 0; k < 14; k++) begin
      step();
      set_issue(k % NL, tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].imm, tbl[k].use_imm,
                5'(k), 5'(k), tbl[k].want, 1'b1);
    end
    drain("ops");
  endtask

  task automatic test_back_to_back();
    bit saw_full = 1'b0;
    for (int i = 0; i < NL; i++) occ[i] = 0;
    grant_log.delete();
    log_grants = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      for (int ln = 0; ln < NL; ln++) begin
        vectors++;
        if (bus.issue_ready[ln] !== 1'((occ[ln] < BD) ? 1 : 0)) begin
          errors++;
          $display("FAIL b2b_ready cycle=%0d lane=%0d issue_ready=%b, required %0d (buffered %0d)",
                   c, ln, bus.issue_ready[ln], (occ[ln] < BD) ? 1 : 0, occ[ln]);
        end
        if (occ[ln] >= BD) saw_full = 1'b1;
        else set_issue(ln, ALU_ADD, 32'(c), 32'(ln), 32'h0, 1'b0, 5'(c), 5'(c), 32'(c + ln), 1'b1);
      end
    end
    step();
    log_grants = 1'b0;
    drain("b2b");
    vectors++;
    if (saw_full !== 1'b1) begin
      errors++;
      $display("FAIL b2b_full saw_full=%b, required 1", saw_full);
    end
    for (int i = 1; i < grant_log.size(); i++) begin
      vectors++;
      if (grant_log[i] == grant_log[i-1]) begin
        errors++;
        $display("FAIL b2b_alternate grant %0d lane=%0d, required lane other than %0d",
                 i, grant_log[i], grant_log[i-1]);
      end
    end
  endtask

  task automatic test_flush();
    bus.rob_head = 5'd30;
    step();
    set_issue(0, ALU_ADD, 32'd100, 32'd1, 32'h0, 1'b0, 5'd31, 5'd2, 32'd101, 1'b1);
    set_issue(1, ALU_ADD, 32'd200, 32'd1, 32'h0, 1'b0, 5'd0,  5'd3, 32'd201, 1'b1);
    step();
    set_issue(0, ALU_ADD, 32'd300, 32'd1, 32'h0, 1'b0, 5'd2,  5'd4, 32'd301, 1'b0);
    set_issue(1, ALU_ADD, 32'd400, 32'd1, 32'h0, 1'b0, 5'd0,  5'd5, 32'd401, 1'b1);
    step();
    set_issue(0, ALU_ADD, 32'd500, 32'd1, 32'h0, 1'b0, 5'd5,  5'd6, 32'd501, 1'b0);
    set_issue(1, ALU_ADD, 32'd600, 32'd1, 32'h0, 1'b0, 5'd1,  5'd7, 32'd601, 1'b1);
    step();
    bus.mispredict     = 1'b1;
    bus.mispredict_tag = 5'd1;
    set_issue(0, ALU_ADD, 32'd700, 32'd1, 32'h0, 1'b0, 5'd6,  5'd8, 32'd701, 1'b0);
    set_issue(1, ALU_ADD, 32'd800, 32'd1, 32'h0, 1'b0, 5'd30, 5'd9, 32'd801, 1'b1);
    drain("flush");
    vectors++;
    if (bus.issue_ready !== {NL{1'b1}}) begin
      errors++;
      $display("FAIL flush_credit issue_ready=%b, required %b", bus.issue_ready, {NL{1'b1}});
    end
    bus.rob_head = 5'd0;
  endtask

  task automatic test_reset_mid();
    step();
    set_issue(0, ALU_XOR, 32'h1, 32'h3, 32'h0, 1'b0, 5'd1, 5'd10, 32'h2, 1'b1);
    set_issue(1, ALU_OR,  32'h1, 32'h4, 32'h0, 1'b0, 5'd2, 5'd11, 32'h5, 1'b1);
    step();
    set_issue(0, ALU_XOR, 32'h2, 32'h3, 32'h0, 1'b0, 5'd3, 5'd12, 32'h1, 1'b1);
    set_issue(1, ALU_OR,  32'h2, 32'h4, 32'h0, 1'b0, 5'd4, 5'd13, 32'h6, 1'b1);
    step();
    vectors++;
    if (bus.cdb_valid === '0) begin
      errors++;
      $display("FAIL rst_mid_pre cdb_valid=%b, required a buffered result", bus.cdb_valid);
    end
    reset = 1'b0;
    #1;
    for (int i = 0; i < NL; i++) begin
      exp_q[i].delete();
      occ[i] = 0;
    end
    vectors++;
    if (bus.cdb_valid !== '0) begin
      errors++;
      $display("FAIL rst_mid_cdb cdb_valid=%b, required 0", bus.cdb_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    vectors++;
    if (bus.issue_ready !== {NL{1'b1}}) begin
      errors++;
      $display("FAIL rst_mid_ready issue_ready=%b, required %b", bus.issue_ready, {NL{1'b1}});
    end
    repeat (4) step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fu_cluster.md
FU_CLUSTER -- requirements
Module: fu_cluster

Interface
REQ-001 Parameter NUM_LANES, default 2, sets the number of independent single-cycle ALU lanes, range 1..4.
REQ-002 Parameter NUM_CDB, default 1, sets the number of completion (CDB) ports, range 1..NUM_LANES.
REQ-003 Parameter BUF_DEPTH, default 4, sets the per-lane result buffer depth, a power of two, range 2..8.
REQ-004 Ports are: clk, input, 1 bit, the single clock; reset, input, 1 bit, asynchronous active-low reset.
REQ-005 Port issue_valid, input, NUM_LANES bits, means the RS issues to lane i this cycle.
REQ-006 Port issue_data, input, NUM_LANES x rs_data, carries the issued op, ROB tag, physical destination, imm and use_imm.
REQ-007 Ports ps1_data and ps2_data, input, NUM_LANES x 32 bits, carry PRF read data aligned with the issue.
REQ-008 Port issue_ready, output, NUM_LANES bits, means lane i accepts an issue this cycle.
REQ-009 Ports rob_head, input, 5 bits, and mispredict, input, 1 bit, carry the ROB head and the flush strobe.
REQ-010 Port mispredict_tag, input, 5 bits, carries the ROB tag of the mispredicted branch.
REQ-011 Port cdb_valid, output, NUM_CDB bits, means CDB port k carries a result.
REQ-012 Port cdb_data, output, NUM_CDB x alu_data, carries the result, ROB tag and physical destination.

Function
REQ-013 Each lane SHALL compute the result combinationally in the issue cycle for ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA and LUI; operand B is imm when use_imm=1, otherwise ps2_data.
REQ-014 Shift amounts SHALL use operand B[4:0], all arithmetic SHALL wrap at 32 bits, and SLT/SLTU SHALL produce 32'd1 or 32'd0.
REQ-015 The lane SHALL push the result into its FIFO buffer at the end of the issue cycle; the earliest CDB visibility is cycle t+1, with no same-cycle bypass.
REQ-016 issue_ready[i] SHALL be (count_i < BUF_DEPTH), from registered count only; a same-cycle pop SHALL NOT grant credit.
REQ-017 An issue with issue_ready[i]=0 SHALL be dropped, and the bench SHALL flag it as an error.
REQ-018 Each buffer slot SHALL hold a valid bit; count_i SHALL include invalidated slots until they are popped.
REQ-019 The arbiter SHALL grant up to NUM_CDB lanes per cycle whose head slot is valid, searching round-robin from rr_ptr.
REQ-020 After any grant, rr_ptr SHALL advance to the lane after the last granted lane; with no grant, rr_ptr SHALL hold.
REQ-021 cdb_valid/cdb_data SHALL be driven combinationally from the granted heads, filling port 0 upward, and a granted head SHALL pop at the clock edge.
REQ-022 A head slot with valid=0 SHALL pop without a grant, at most one per lane per cycle, and SHALL consume no CDB port.
REQ-023 Age SHALL be defined as (tag - rob_head) mod 32; an entry is younger when its age exceeds (mispredict_tag - rob_head) mod 32.
REQ-024 When mispredict=1, all buffered younger entries SHALL clear valid at the edge, and any younger same-cycle issue SHALL NOT be pushed.
REQ-025 When mispredict=1, cdb_valid SHALL be masked combinationally for younger heads in that cycle.
REQ-026 The entry equal to mispredict_tag and all older entries SHALL be unaffected by a mispredict.
REQ-027 A simultaneous push and pop on a lane SHALL leave count_i unchanged, and the write and read pointers SHALL wrap modulo BUF_DEPTH.

Reset
REQ-028 While reset=0, all counts, pointers, slot valid bits and rr_ptr SHALL be 0 and cdb_valid SHALL be 0; issue_ready SHALL be all ones.
REQ-029 Reset asserted mid-operation SHALL discard all buffered results with no CDB output.

Structure
REQ-030 rs_data, alu_data, the ALU opcode enum and ROB_TAG_W=5 SHALL live in the shared package.
REQ-031 One sub-module, alu_lane, SHALL contain the per-lane ALU, the FIFO and the flush logic; the arbiter SHALL stay in fu_cluster.

Verification
REQ-032 Lane 0 ADD with ps1=5 and ps2=7 in cycle 0 -> cdb_valid[0]=1 and result 12 in cycle 1.
REQ-033 SRA with ps1=0x80000000 and imm=4, use_imm=1 -> result 0xF8000000; SLTU with 1 vs 0xFFFFFFFF -> result 1.
REQ-034 NUM_LANES=2, NUM_CDB=1, both lanes issue every cycle -> grants alternate 0,1,0,1.
REQ-035 Same setup: issue_ready drops after 4 buffered results and recovers one cycle after a pop.
REQ-036 rob_head=30, buffered tags 31, 2 and 5, mispredict_tag=1 -> tags 2 and 5 never appear on the CDB, and tag 31 completes.
REQ-037 Pulse reset with 3 results buffered -> cdb_valid=0 immediately, and issue_ready is all ones after release.
